// File: rtl/rom_arbiter.sv
// Three-way round-robin arbiter that shares one SDRAM ROM read port.
// Each requester holds req until its one-cycle valid; a RELEASE cycle separates grants.
module rom_arbiter #(
   parameter int AW = 23,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          req2,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [AW-1:0] addr2,
   output logic          valid0,
   output logic          valid1,
   output logic          valid2,
   output logic [DW-1:0] data0,
   output logic [DW-1:0] data1,
   output logic [DW-1:0] data2,
   output logic          sdram_req,
   output logic [AW-1:0] sdram_addr,
   input  logic [DW-1:0] sdram_data,
   input  logic          sdram_valid,
   output logic [1:0]    grant,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, WAIT, RELEASE} state_t;

   localparam logic [1:0] NONE = 2'd3;

   state_t          state, state_next;
   logic [1:0]      last;
   logic [2:0]      req_vec;
   logic [2:0]      valid_q;
   logic [DW-1:0]   data_q [3];
   logic [1:0]      start, cand1, cand2, pick;
   logic [AW-1:0]   pick_addr;
   logic            grant_en;
   logic            capture;

   function automatic logic [1:0] wrap3(input logic [2:0] v);
      logic [2:0] t;
      t = (v >= 3'd3) ? v - 3'd3 : v;
      return t[1:0];
   endfunction

   assign req_vec = {req2, req1, req0};

   // Search order is last+1, last+2, last (mod 3), so the previous owner goes last.
   assign start = wrap3({1'b0, last} + 3'd1);
   assign cand1 = wrap3({1'b0, start} + 3'd1);
   assign cand2 = wrap3({1'b0, start} + 3'd2);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
      pick = start;
      if (req_vec[start])
         pick = start;
      else if (req_vec[cand1])
         pick = cand1;
      else if (req_vec[cand2])
         pick = cand2;
   end

   always_comb begin
      pick_addr = addr2;
      case (pick)
         2'd0:    pick_addr = addr0;
         2'd1:    pick_addr = addr1;
         default: pick_addr = addr2;
      endcase
   end

   always_comb begin
      state_next = state;
      grant_en   = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (|req_vec) begin
               grant_en   = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (sdram_valid) begin
               capture    = 1'b1;
               state_next = RELEASE;
            end
         end
         RELEASE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last       <= 2'd2;
         grant      <= NONE;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         valid_q    <= '0;
         // NOTE: the read-data registers are only three words, so they are cleared with the rest rather than left unreset.
         for (int i = 0; i < 3; i++)
            data_q[i] <= '0;
      end else begin
         valid_q <= '0;
         if (grant_en) begin
            sdram_req  <= 1'b1;
            sdram_addr <= pick_addr;
            grant      <= pick;
            last       <= pick;
         end
         if (capture) begin
            sdram_req <= 1'b0;
            grant     <= NONE;
            // An owner that dropped req during WAIT has aborted; its data is discarded.
            if (req_vec[last]) begin
               valid_q[last] <= 1'b1;
               data_q[last]  <= sdram_data;
            end
         end
      end
   end

   assign valid0 = valid_q[0];
   assign valid1 = valid_q[1];
   assign valid2 = valid_q[2];
   assign data0  = data_q[0];
   assign data1  = data_q[1];
   assign data2  = data_q[2];
   assign busy   = (state != IDLE);

endmodule
